// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: four one-entry holding buffers feed a round-robin
// arbiter that drives one registered result per cycle onto the CDB.
module cdb_arbiter #(
  parameter int ROB_W  = 3,
  parameter int DATA_W = 32,
  parameter int NREQ   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*ROB_W-1:0]   req_rob_index,
  input  logic [NREQ*DATA_W-1:0]  req_data,
  output logic [ROB_W-1:0]        CDB_ROB_index,
  output logic [DATA_W-1:0]       CDB_data,
  output logic [1:0]              CDB_src,
  output logic [CNT_W-1:0]        conflict_cnt
);

  logic [NREQ-1:0]   buf_valid_q, buf_valid_d;
  logic [ROB_W-1:0]  buf_idx_q  [NREQ];
  logic [ROB_W-1:0]  buf_idx_d  [NREQ];
  logic [DATA_W-1:0] buf_data_q [NREQ];
  logic [DATA_W-1:0] buf_data_d [NREQ];
  logic [NREQ-1:0]   capture;

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [ROB_W-1:0]  cdb_idx_q, cdb_idx_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [1:0]        cdb_src_q, cdb_src_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic [NREQ-1:0]   grant;
  logic              grant_any;
  logic [1:0]        grant_id;
  logic [1:0]        search_id;
  logic [2:0]        valid_count;

  // Walk the search order from farthest to nearest so the nearest valid
  // buffer (starting at rr_ptr) is the one left standing.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = rr_ptr_q;
    search_id = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      search_id = rr_ptr_q + 2'(k);
      if (buf_valid_q[search_id]) begin
        grant_any = 1'b1;
        grant_id  = search_id;
      end
    end
    grant = grant_any ? (NREQ'(1) << grant_id) : '0;
  end

  always_comb begin
    valid_count = '0;
    for (int i = 0; i < NREQ; i++) begin
      valid_count = valid_count + 3'(buf_valid_q[i]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_buf
      // A buffer being granted this cycle is free again at the edge, so it may refill.
      assign req_ready[gi] = ~buf_valid_q[gi] | grant[gi];
      assign capture[gi]   = req_valid[gi] & req_ready[gi] & ~flush &
                             (req_rob_index[gi*ROB_W +: ROB_W] != '0);

      always_comb begin
        buf_valid_d[gi] = buf_valid_q[gi];
        buf_idx_d[gi]   = buf_idx_q[gi];
        buf_data_d[gi]  = buf_data_q[gi];
        if (flush) begin
          buf_valid_d[gi] = 1'b0;
        end else if (capture[gi]) begin
          buf_valid_d[gi] = 1'b1;
          buf_idx_d[gi]   = req_rob_index[gi*ROB_W +: ROB_W];
          buf_data_d[gi]  = req_data[gi*DATA_W +: DATA_W];
        end else if (grant[gi]) begin
          buf_valid_d[gi] = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_valid_q[gi] <= 1'b0;
          buf_idx_q[gi]   <= '0;
          buf_data_q[gi]  <= '0;
        end else begin
          buf_valid_q[gi] <= buf_valid_d[gi];
          buf_idx_q[gi]   <= buf_idx_d[gi];
          buf_data_q[gi]  <= buf_data_d[gi];
        end
      end
    end
  endgenerate

  // Data and source hold across idle cycles; only the index returns to 0.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    cdb_idx_d      = '0;
    cdb_data_d     = cdb_data_q;
    cdb_src_d      = cdb_src_q;
    conflict_cnt_d = conflict_cnt_q;
    if (!flush) begin
      if (grant_any) begin
        cdb_idx_d  = buf_idx_q[grant_id];
        cdb_data_d = buf_data_q[grant_id];
        cdb_src_d  = grant_id;
        rr_ptr_d   = grant_id + 2'd1;
      end
      if (valid_count >= 3'd2 && conflict_cnt_q != '1) begin
        conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      cdb_idx_q      <= '0;
      cdb_data_q     <= '0;
      cdb_src_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      cdb_idx_q      <= cdb_idx_d;
      cdb_data_q     <= cdb_data_d;
      cdb_src_q      <= cdb_src_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign CDB_ROB_index = cdb_idx_q;
  assign CDB_data      = cdb_data_q;
  assign CDB_src       = cdb_src_q;
  assign conflict_cnt  = conflict_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [11:0]  req_rob_index;
  logic [127:0] req_data;
  logic [2:0]   CDB_ROB_index;
  logic [31:0]  CDB_data;
  logic [1:0]   CDB_src;
  logic [15:0]  conflict_cnt;

  logic [2:0]   tb_idx  [4];
  logic [31:0]  tb_data [4];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_valid [4];
  int          m_idx   [4];
  logic [31:0] m_data  [4];
  int          m_ptr;
  int          m_cdb_idx;
  logic [31:0] m_cdb_data;
  int          m_cdb_src;
  int          m_cnt;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rob_index(req_rob_index), .req_data(req_data),
    .CDB_ROB_index(CDB_ROB_index), .CDB_data(CDB_data), .CDB_src(CDB_src),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_rob_index = '0;
    req_data      = '0;
    for (int i = 0; i < 4; i++) begin
      req_rob_index[i*3 +: 3] = tb_idx[i];
      req_data[i*32 +: 32]    = tb_data[i];
    end
  end

  function automatic int m_grant();
    for (int k = 0; k < 4; k++) begin
      if (m_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    int g;
    g = m_grant();
    for (int i = 0; i < 4; i++) r[i] = !m_valid[i] || (g == i);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_idx[i] = 0; m_data[i] = '0;
    end
    m_ptr = 0; m_cdb_idx = 0; m_cdb_data = '0; m_cdb_src = 0; m_cnt = 0;
  endtask

  // One clock edge of the specified behaviour, from the current inputs.
  task automatic model_edge();
    int g;
    int busy;
    logic [3:0] rdy;
    g = m_grant();
    rdy = m_ready();
    busy = 0;
    for (int i = 0; i < 4; i++) busy += m_valid[i] ? 1 : 0;
    if (flush) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 0;
      m_cdb_idx = 0;
    end else begin
      m_cdb_idx = 0;
      if (g >= 0) begin
        m_cdb_idx = m_idx[g]; m_cdb_data = m_data[g]; m_cdb_src = g;
        m_valid[g] = 0;
        m_ptr = (g + 1) % 4;
      end
      if (busy >= 2 && m_cnt < 65535) m_cnt++;
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && rdy[i] && tb_idx[i] != 0) begin
          m_valid[i] = 1; m_idx[i] = tb_idx[i]; m_data[i] = tb_data[i];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tb_idx[i] = '0; tb_data[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (CDB_ROB_index !== 3'd0 || CDB_data !== 32'd0 || CDB_src !== 2'd0 || conflict_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs got idx=%0d data=%h src=%0d cnt=%0d want all 0",
               CDB_ROB_index, CDB_data, CDB_src, conflict_cnt);
    end
    total++;
    if (req_ready !== 4'b1111) begin
      bad++; $display("FAIL reset_ready got=%b want=1111", req_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_alu();
    do_reset();
    req_valid = 4'b0001; tb_idx[0] = 3'd3; tb_data[0] = 32'hDEADBEEF;
    tick();
    clear_inputs();
    total++;
    if (CDB_ROB_index !== 3'd0 || req_ready !== 4'b1111) begin
      bad++; $display("FAIL single_edge1 got idx=%0d ready=%b want idx=0 ready=1111", CDB_ROB_index, req_ready);
    end
    tick();
    total++;
    if (CDB_ROB_index !== 3'd3 || CDB_data !== 32'hDEADBEEF || CDB_src !== 2'd0) begin
      bad++; $display("FAIL single_bcast got idx=%0d data=%h src=%0d want 3 deadbeef 0",
                      CDB_ROB_index, CDB_data, CDB_src);
    end
    tick();
    total++;
    if (CDB_ROB_index !== 3'd0 || req_ready !== 4'b1111) begin
      bad++; $display("FAIL single_idle got idx=%0d ready=%b want 0 1111", CDB_ROB_index, req_ready);
    end
    $display("test_single_alu done");
  endtask

  task automatic test_contention();
    logic [3:0] exp_ready;
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tb_idx[i] = 3'(i + 1); tb_data[i] = 32'h1000 + 32'(i);
    end
    tick();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      exp_ready = 4'((1 << (c + 1)) - 1);
      total++;
      if (req_ready !== exp_ready) begin
        bad++; $display("FAIL contend_ready[%0d] got=%b want=%b", c, req_ready, exp_ready);
      end
      tick();
      total++;
      if (CDB_ROB_index !== 3'(c + 1) || CDB_src !== 2'(c) || CDB_data !== 32'h1000 + 32'(c)) begin
        bad++; $display("FAIL contend_bcast[%0d] got idx=%0d src=%0d want idx=%0d src=%0d",
                        c, CDB_ROB_index, CDB_src, c + 1, c);
      end
    end
    tick();
    total++;
    if (conflict_cnt !== 16'd3 || CDB_ROB_index !== 3'd0) begin
      bad++; $display("FAIL contend_cnt got cnt=%0d idx=%0d want cnt=3 idx=0", conflict_cnt, CDB_ROB_index);
    end
    $display("test_contention done");
  endtask

  task automatic test_fairness();
    do_reset();
    for (int n = 0; n < 6; n++) begin
      req_valid = 4'b0011;
      tb_idx[0] = 3'($urandom_range(1, 7)); tb_data[0] = $urandom;
      tb_idx[1] = 3'($urandom_range(1, 7)); tb_data[1] = $urandom;
      tick();
      if (n >= 1) begin
        total++;
        if (CDB_ROB_index === 3'd0 || CDB_src !== 2'((n - 1) % 2) ||
            CDB_ROB_index !== 3'(m_cdb_idx) || CDB_data !== m_cdb_data) begin
          bad++; $display("FAIL fair[%0d] got idx=%0d src=%0d want idx=%0d src=%0d",
                          n, CDB_ROB_index, CDB_src, m_cdb_idx, (n - 1) % 2);
        end
      end
    end
    clear_inputs();
    $display("test_fairness done");
  endtask

  task automatic test_refill();
    do_reset();
    req_valid = 4'b0001; tb_idx[0] = 3'd5; tb_data[0] = 32'hAAAA0005;
    tick();
    tb_idx[0] = 3'd6; tb_data[0] = 32'hBBBB0006;
    total++;
    if (req_ready[0] !== 1'b1) begin
      bad++; $display("FAIL refill_ready got=%b want=1", req_ready[0]);
    end
    tick();
    clear_inputs();
    total++;
    if (CDB_ROB_index !== 3'd5 || CDB_data !== 32'hAAAA0005) begin
      bad++; $display("FAIL refill_first got idx=%0d data=%h want 5 aaaa0005", CDB_ROB_index, CDB_data);
    end
    tick();
    total++;
    if (CDB_ROB_index !== 3'd6 || CDB_data !== 32'hBBBB0006) begin
      bad++; $display("FAIL refill_second got idx=%0d data=%h want 6 bbbb0006", CDB_ROB_index, CDB_data);
    end
    $display("test_refill done");
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 4'b1100;
    tb_idx[2] = 3'd2; tb_data[2] = 32'h22;
    tb_idx[3] = 3'd7; tb_data[3] = 32'h77;
    tick();
    clear_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (CDB_ROB_index !== 3'd0 || conflict_cnt !== 16'd0) begin
      bad++; $display("FAIL flush_edge got idx=%0d cnt=%0d want 0 0", CDB_ROB_index, conflict_cnt);
    end
    req_valid = 4'b0010; tb_idx[1] = 3'd4; tb_data[1] = 32'h44;
    tick();
    clear_inputs();
    total++;
    if (CDB_ROB_index !== 3'd0) begin
      bad++; $display("FAIL flush_stale got idx=%0d want 0", CDB_ROB_index);
    end
    tick();
    total++;
    if (CDB_ROB_index !== 3'd4 || CDB_src !== 2'd1 || CDB_data !== 32'h44) begin
      bad++; $display("FAIL flush_after got idx=%0d src=%0d want 4 1", CDB_ROB_index, CDB_src);
    end
    tick();
    total++;
    if (CDB_ROB_index !== 3'd0) begin
      bad++; $display("FAIL flush_tail got idx=%0d want 0", CDB_ROB_index);
    end
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      tb_idx[i] = 3'(i + 1); tb_data[i] = 32'h300 + 32'(i);
    end
    tick();
    clear_inputs();
    tick();
    total++;
    if (CDB_ROB_index !== 3'd1 || conflict_cnt !== 16'd1) begin
      bad++; $display("FAIL areset_pre got idx=%0d cnt=%0d want 1 1", CDB_ROB_index, conflict_cnt);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (CDB_ROB_index !== 3'd0 || conflict_cnt !== 16'd0 || req_ready !== 4'b1111) begin
      bad++; $display("FAIL areset_now got idx=%0d cnt=%0d ready=%b want 0 0 1111",
                      CDB_ROB_index, conflict_cnt, req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    total++;
    if (CDB_ROB_index !== 3'd0) begin
      bad++; $display("FAIL areset_lost got idx=%0d want 0", CDB_ROB_index);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_index_zero();
    do_reset();
    req_valid = 4'b0001; tb_idx[0] = 3'd0; tb_data[0] = 32'h12345678;
    total++;
    if (req_ready[0] !== 1'b1) begin
      bad++; $display("FAIL idx0_ready got=%b want=1", req_ready[0]);
    end
    tick();
    clear_inputs();
    tick();
    total++;
    if (CDB_ROB_index !== 3'd0 || req_ready !== 4'b1111 || CDB_data !== 32'd0) begin
      bad++; $display("FAIL idx0_ignored got idx=%0d ready=%b data=%h want 0 1111 0",
                      CDB_ROB_index, req_ready, CDB_data);
    end
    $display("test_index_zero done");
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 4; i++) begin
        tb_idx[i] = 3'($urandom_range(0, 7)); tb_data[i] = $urandom;
      end
      total++;
      if (req_ready !== m_ready()) begin
        bad++; errs++;
        $display("FAIL rand_ready[%0d] got=%b want=%b", n, req_ready, m_ready());
      end
      tick();
      total++;
      if (CDB_ROB_index !== 3'(m_cdb_idx) || CDB_data !== m_cdb_data ||
          CDB_src !== 2'(m_cdb_src) || conflict_cnt !== 16'(m_cnt)) begin
        bad++; errs++;
        $display("FAIL rand_cdb[%0d] got idx=%0d data=%h src=%0d cnt=%0d want idx=%0d data=%h src=%0d cnt=%0d",
                 n, CDB_ROB_index, CDB_data, CDB_src, conflict_cnt,
                 m_cdb_idx, m_cdb_data, m_cdb_src, m_cnt);
      end
    end
    clear_inputs();
    $display("test_random done cycles=400 errors=%0d", errs);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single_alu();
    test_contention();
    test_fairness();
    test_refill();
    test_flush();
    test_async_reset();
    test_index_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among four result producers: ALU, load unit, multiplier and divider.
- The CDB writes results into the reorder buffer's ROB entry `Ready`/value fields.
- Each producer has a one-entry holding buffer. A round-robin arbiter picks one buffered result per cycle and drives it, registered, onto the CDB index/data lines.
- ROB index 0 on the CDB means "no broadcast".

Parameters:
- ROB_W, 3, width of a ROB index; index 0 is reserved as "none".
- DATA_W, 32, result data width.
- NREQ, 4, number of requesters; fixed at 4 (0=ALU, 1=LOAD, 2=MUL, 3=DIV); arbiter logic is written for 4.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash (mispredict/exception).
- req_valid  in  NREQ  per-requester result valid.
- req_ready  out  NREQ  per-requester holding buffer can accept this cycle.
- req_rob_index  in  NREQ*ROB_W  packed ROB index; requester i at bits [i*ROB_W +: ROB_W].
- req_data  in  NREQ*DATA_W  packed result data, same packing.
- CDB_ROB_index  out  ROB_W  broadcast ROB index; 0 = idle.
- CDB_data  out  DATA_W  broadcast result.
- CDB_src  out  2  requester id of the current broadcast.
- conflict_cnt  out  CNT_W  saturating count of cycles where more than one buffer was valid.

Behaviour:
- Reset (async, rst=1):
  - buf_valid all 0; rr_ptr=0.
  - CDB_ROB_index=0, CDB_data=0, CDB_src=0, conflict_cnt=0.
- Holding buffers, per i:
  - buf_valid[i], buf_idx[i], buf_data[i].
  - req_ready[i] = ~buf_valid[i] | grant[i] (combinational; a buffer draining this cycle can refill in the same cycle).
  - Capture at the edge when req_valid[i] & req_ready[i] & (req_rob_index[i] != 0) & ~flush.
  - A request with index 0 is ignored and never captured; ready is still reported.
- Arbitration (combinational on buf_valid):
  - Search order is rr_ptr, rr_ptr+1, … mod 4.
  - Grant the first valid buffer; the grant is one-hot or zero.
  - After a grant to requester g, rr_ptr <= (g+1) mod 4. rr_ptr is unchanged when there is no grant.
- Broadcast (registered):
  - On a grant, at the next edge: CDB_ROB_index<=buf_idx[g], CDB_data<=buf_data[g], CDB_src<=g; buf_valid[g] clears unless refilled in the same cycle.
  - With no grant: CDB_ROB_index<=0. CDB_data and CDB_src hold their previous values.
  - Each broadcast lasts exactly one cycle.
- Latency:
  - Result presented at edge N with an empty buffer and no competition appears on the CDB after edge N+1 (two edges, valid for one cycle).
  - Throughput is one result per cycle total; one per cycle per requester when uncontended.
- Flush (priority over everything):
  - At the edge: all buf_valid<=0, CDB_ROB_index<=0, no captures.
  - rr_ptr and conflict_cnt are unchanged.
  - req_ready during the flush cycle follows normal rules, but accepted data is discarded.
- conflict_cnt:
  - Increments when popcount(buf_valid) >= 2 and ~flush.
  - Saturates at 2^CNT_W-1; cleared only by reset.
- Simultaneous events:
  - Grant to g and a new capture on g in the same cycle: buffer reloads with the new value; the old value is broadcast.
  - Captures on several requesters in one cycle are all accepted.
- Reset mid-operation: all state clears immediately (asynchronous); in-flight buffered results are lost; the first edge after rst falls behaves as after power-up.
- No back-pressure from the ROB. The CDB target index is guaranteed valid by the producers.

Test Plan:
- Single ALU result: req_valid=0001, idx=3, data=0xDEADBEEF at edge 1 → CDB_ROB_index=3, CDB_data=0xDEADBEEF, CDB_src=0 for one cycle after edge 2, then 0; req_ready stays 1111.
- Four-way contention from reset (rr_ptr=0): all four present idx 1,2,3,4 at edge 1 → CDB sequence 1,2,3,4 on consecutive cycles with src 0,1,2,3; req_ready[1..3] low while their buffers are held; conflict_cnt=3.
- Round-robin fairness: ALU and LOAD both present every cycle for 6 cycles → CDB_src alternates 0,1,0,1,…; neither requester is skipped twice in a row.
- Refill on grant: ALU presents idx 5 then idx 6 on back-to-back cycles with no contention → req_ready[0] stays 1; CDB shows 5 then 6 on consecutive cycles.
- Flush: MUL and DIV buffered (idx 2, 7), flush=1 for one cycle → neither index ever appears on the CDB; CDB_ROB_index=0 after the flush edge; a LOAD idx 4 presented the next cycle broadcasts normally.
- Async reset mid-stream, plus index-0 filter: assert rst between edges with 3 buffers valid → CDB_ROB_index=0 and conflict_cnt=0 immediately, without waiting for a clock edge. Separately, req_valid with idx 0 → no broadcast, buffer stays empty.
